// File: rtl/keccak_pkg.sv
// Shared Keccak geometry, lane indexing and theta FSM encoding.
package keccak_pkg;

  localparam int unsigned NUM_X     = 5;
  localparam int unsigned NUM_Y     = 5;
  localparam int unsigned NUM_LANES = NUM_X * NUM_Y;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } theta_state_e;

  // Bit offset of lane (x,y) inside a group of sp slices.
  function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                      input int unsigned sp);
    return (NUM_Y * x + y) * sp;
  endfunction

  // Ceiling log2, never below 1 so a single-group round still has a counter bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_col_parity.sv
// Combinational column parity of a slice group: bit x*SP+k = XOR over y of lane (x,y) bit k.
module keccak_col_parity
  import keccak_pkg::*;
#(
  parameter int unsigned SP = 1
) (
  input  logic [NUM_LANES*SP-1:0] SlicesxDI,
  output logic [NUM_X*SP-1:0]     ParityxDO
);

  always_comb begin
    ParityxDO = '0;
    for (int unsigned x = 0; x < NUM_X; x++) begin
      for (int unsigned y = 0; y < NUM_Y; y++) begin
        for (int unsigned k = 0; k < SP; k++) begin
          ParityxDO[x*SP+k] = ParityxDO[x*SP+k] ^ SlicesxDI[idx(x, y, SP)+k];
        end
      end
    end
  end

endmodule

// File: rtl/keccak_theta_slices.sv
// Slice-serial Keccak theta step with a priming beat for the slice-0 wrap-around parity.
// Optional KECCAK_THETA_BYPASS_EN adds BypassxSI to pass slices through unmodified for a round.
module keccak_theta_slices
  import keccak_pkg::*;
#(
  parameter int unsigned SLICES_PARALLEL = 1,
  parameter int unsigned LANE_WIDTH      = 64
) (
  input  logic                                ClkxCI,
  input  logic                                RstxRI,
  input  logic [NUM_LANES*SLICES_PARALLEL-1:0] SlicesxDI,
  input  logic                                InValidxSI,
  output logic                                InReadyxSO,
  output logic [NUM_LANES*SLICES_PARALLEL-1:0] SlicesxDO,
  output logic                                OutValidxSO,
  input  logic                                OutReadyxSI,
  output logic                                LastxSO,
`ifdef KECCAK_THETA_BYPASS_EN
  input  logic                                BypassxSI,
`endif
  output theta_state_e                        DbgStatexSO
);

  localparam int unsigned SP   = SLICES_PARALLEL;
  localparam int unsigned NGRP = LANE_WIDTH / SP;
  localparam int unsigned GW   = clog2_min1(NGRP);
  localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

  theta_state_e            state_q, state_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic [NUM_X-1:0]        cprev_q, cprev_d;
  logic [NUM_LANES*SP-1:0] out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    last_q, last_d;
`ifdef KECCAK_THETA_BYPASS_EN
  logic                    bypass_q, bypass_d;
`endif

  logic [NUM_X*SP-1:0]     par;
  logic [NUM_X-1:0]        top_par;
  logic [NUM_LANES*SP-1:0] theta_slices;
  logic                    in_fire;

  keccak_col_parity #(.SP(SP)) u_col_parity (
    .SlicesxDI (SlicesxDI),
    .ParityxDO (par)
  );

  // Handshake: a beat moves when valid and ready are high in the same cycle.
  // PRIME always accepts; RUN accepts when the output register is empty or draining.
  assign InReadyxSO  = (state_q == ST_PRIME) ? 1'b1 : (~out_valid_q | OutReadyxSI);
  assign in_fire     = InValidxSI & InReadyxSO;
  assign SlicesxDO   = out_q;
  assign OutValidxSO = out_valid_q;
  assign LastxSO     = last_q;
  assign DbgStatexSO = state_q;

  always_comb begin
    top_par = '0;
    for (int unsigned x = 0; x < NUM_X; x++) top_par[x] = par[x*SP+SP-1];
  end

  // Slice 0 of a group borrows its z-1 parity from the previous group's top slice.
  always_comb begin
    logic nbr;
    nbr          = 1'b0;
    theta_slices = '0;
    for (int unsigned x = 0; x < NUM_X; x++) begin
      for (int unsigned y = 0; y < NUM_Y; y++) begin
        for (int unsigned k = 0; k < SP; k++) begin
          if (k == 0) nbr = cprev_q[(x+1)%NUM_X];
          else        nbr = par[((x+1)%NUM_X)*SP + (k+SP-1)%SP];
          theta_slices[idx(x, y, SP)+k] = SlicesxDI[idx(x, y, SP)+k]
                                        ^ par[((x+NUM_X-1)%NUM_X)*SP+k] ^ nbr;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    cprev_d     = cprev_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
`ifdef KECCAK_THETA_BYPASS_EN
    bypass_d    = bypass_q;
`endif
    if (out_valid_q && OutReadyxSI) begin
      out_valid_d = 1'b0;
      last_d      = 1'b0;
    end
    unique case (state_q)
      ST_PRIME: begin
        if (in_fire) begin
          cprev_d = top_par;
          grp_d   = '0;
          state_d = ST_RUN;
`ifdef KECCAK_THETA_BYPASS_EN
          bypass_d = BypassxSI;
`endif
        end
      end
      ST_RUN: begin
        if (in_fire) begin
`ifdef KECCAK_THETA_BYPASS_EN
          out_d = bypass_q ? SlicesxDI : theta_slices;
`else
          out_d = theta_slices;
`endif
          out_valid_d = 1'b1;
          last_d      = (grp_q == LAST_GRP);
          cprev_d     = top_par;
          if (grp_q == LAST_GRP) begin
            grp_d   = '0;
            state_d = ST_PRIME;
          end else begin
            grp_d = grp_q + GW'(1);
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q     <= ST_PRIME;
      grp_q       <= '0;
      cprev_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
`ifdef KECCAK_THETA_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      cprev_q     <= cprev_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
`ifdef KECCAK_THETA_BYPASS_EN
      bypass_q    <= bypass_d;
`endif
    end
  end

endmodule
